// File: rtl/difftest_hcsr_pkg.sv
// Shared types for the hypervisor-CSR difftest arbiter.
// Optional feature macro used by the top: DIFFTEST_HCSR_DEDUP_EN.
package difftest_hcsr_pkg;

  localparam int HCSR_SNAP_W = 1088;

  // Field order follows the sink's argument order; virtMode lands in the MSBs.
  typedef struct packed {
    logic [63:0] virtMode;
    logic [63:0] mtval2;
    logic [63:0] mtinst;
    logic [63:0] hstatus;
    logic [63:0] hideleg;
    logic [63:0] hedeleg;
    logic [63:0] hcounteren;
    logic [63:0] htval;
    logic [63:0] htinst;
    logic [63:0] hgatp;
    logic [63:0] vsstatus;
    logic [63:0] vstvec;
    logic [63:0] vsepc;
    logic [63:0] vscause;
    logic [63:0] vstval;
    logic [63:0] vsatp;
    logic [63:0] vsscratch;
  } hcsr_snapshot_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/difftest_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr_i wins,
// and the pointer advances to the slot just past the winner.
module difftest_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic [IDX_W-1:0] ptr_next_o
);

  always_comb begin : rr_search
    int cand;
    gnt_o      = '0;
    idx_o      = '0;
    any_o      = 1'b0;
    ptr_next_o = ptr_i;
    cand       = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
        ptr_next_o  = (cand == N - 1) ? '0 : IDX_W'(cand + 1);
      end
    end
  end

endmodule

// File: rtl/difftest_hcsr_arbiter.sv
// Buffers one HCSR snapshot per core and round-robins them onto one registered
// sink port. Define DIFFTEST_HCSR_DEDUP_EN to drop repeats of a core's last emitted snapshot.
module difftest_hcsr_arbiter
  import difftest_hcsr_pkg::*;
#(
  parameter int NUM_CORES    = 2,
  parameter int CORE_ID_BASE = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CORES-1:0]               in_valid,
  output logic [NUM_CORES-1:0]               in_ready,
  input  logic [NUM_CORES*HCSR_SNAP_W-1:0]   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [HCSR_SNAP_W-1:0]             out_data,
  output logic [7:0]                         out_coreid
);

  localparam int         IDX_W   = idx_w(NUM_CORES);
  localparam logic [7:0] ID_BASE = 8'(CORE_ID_BASE);

  logic [NUM_CORES-1:0]   slot_v_q, slot_v_d;
  logic [HCSR_SNAP_W-1:0] slot_data [NUM_CORES];
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [HCSR_SNAP_W-1:0] out_data_q, out_data_d;
  logic [7:0]             out_coreid_q, out_coreid_d;

  logic [NUM_CORES-1:0]   gnt;
  logic [IDX_W-1:0]       gnt_idx, ptr_next;
  logic                   gnt_any, loadable, grant_en;

  assign loadable = !out_valid_q || out_ready;
  assign grant_en = loadable && gnt_any;

  difftest_rr_arbiter #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i      (slot_v_q),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (gnt),
    .idx_o      (gnt_idx),
    .any_o      (gnt_any),
    .ptr_next_o (ptr_next)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_slot
      logic                   accept, drop, v_d;
      logic [HCSR_SNAP_W-1:0] data_q;

      assign accept = in_valid[gi] && !slot_v_q[gi];

`ifdef DIFFTEST_HCSR_DEDUP_EN
      logic                   last_v_q;
      logic [HCSR_SNAP_W-1:0] last_d_q;

      assign drop = last_v_q && (in_data[gi*HCSR_SNAP_W +: HCSR_SNAP_W] == last_d_q);

      always_ff @(posedge clock) begin
        if (reset) begin
          last_v_q <= 1'b0;
        end else if (grant_en && gnt[gi]) begin
          last_v_q <= 1'b1;
          last_d_q <= data_q;
        end
      end
`else
      assign drop = 1'b0;
`endif

      // A slot being granted is full, so grant and accept never coincide.
      always_comb begin
        v_d = slot_v_q[gi];
        if (grant_en && gnt[gi])  v_d = 1'b0;
        else if (accept && !drop) v_d = 1'b1;
      end

      always_ff @(posedge clock) begin
        if (accept && !drop) data_q <= in_data[gi*HCSR_SNAP_W +: HCSR_SNAP_W];
      end

      assign slot_v_d[gi]  = v_d;
      assign slot_data[gi] = data_q;
      assign in_ready[gi]  = !slot_v_q[gi];
    end
  endgenerate

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_coreid_d = out_coreid_q;
    rr_ptr_d     = rr_ptr_q;
    if (loadable) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d   = slot_data[gnt_idx];
        out_coreid_d = ID_BASE + 8'(gnt_idx);
        rr_ptr_d     = ptr_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_v_q     <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_coreid_q <= ID_BASE;
    end else begin
      slot_v_q     <= slot_v_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_coreid_q <= out_coreid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_coreid = out_coreid_q;

endmodule

// File: tb/tb_difftest_hcsr_arbiter.sv
// Directed bench for difftest_hcsr_arbiter (2-core default plus a 3-core, base-4 instance).
module tb_difftest_hcsr_arbiter;
  import difftest_hcsr_pkg::*;

  localparam int W = HCSR_SNAP_W;

  logic           clock = 1'b0;
  logic           reset;
  logic [1:0]     in_valid;
  logic [1:0]     in_ready;
  logic [2*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [7:0]     out_coreid;

  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [3*W-1:0] in_data3;
  logic           out_valid3;
  logic           out_ready3;
  logic [W-1:0]   out_data3;
  logic [7:0]     out_coreid3;

  int total = 0;
  int bad   = 0;
  int out_seen;

  always #5 clock = ~clock;

  difftest_hcsr_arbiter #(.NUM_CORES(2), .CORE_ID_BASE(0)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_coreid (out_coreid)
  );

  difftest_hcsr_arbiter #(.NUM_CORES(3), .CORE_ID_BASE(4)) dut3 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid3),
    .in_ready   (in_ready3),
    .in_data    (in_data3),
    .out_valid  (out_valid3),
    .out_ready  (out_ready3),
    .out_data   (out_data3),
    .out_coreid (out_coreid3)
  );

  function automatic hcsr_snapshot_t mk_snap(input logic [15:0] tag);
    hcsr_snapshot_t s;
    s           = '0;
    s.virtMode  = {63'h0, tag[0]};
    s.hstatus   = {32'hA5A5_0000, 16'h0, tag};
    s.vsepc     = {48'h8000, tag};
    s.vsscratch = ~{48'h0, tag};
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_count();
    tick();
    if (out_valid) out_seen++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = '0;
    in_valid3 = '0;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 2'b11)   begin bad++; $display("FAIL reset_in_ready got=%b exp=11", in_ready); end
    total++; if (out_coreid !== 8'd0)  begin bad++; $display("FAIL reset_coreid got=%0d exp=0", out_coreid); end
    total++; if (out_data !== '0)      begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data[63:0]); end
    total++; if (out_coreid3 !== 8'd4) begin bad++; $display("FAIL reset_coreid3 got=%0d exp=4", out_coreid3); end
    total++; if (in_ready3 !== 3'b111) begin bad++; $display("FAIL reset_in_ready3 got=%b exp=111", in_ready3); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    hcsr_snapshot_t s, o;
    do_reset();
    s = '0;
    s.hstatus = 64'h2_0000_0000;
    in_data[0 +: W] = s;
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%b exp=0", out_valid); end
    total++; if (in_ready !== 2'b10) begin bad++; $display("FAIL single_slot_full got=%b exp=10", in_ready); end
    tick();
    o = out_data;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if (out_coreid !== 8'd0) begin bad++; $display("FAIL single_coreid got=%0d exp=0", out_coreid); end
    total++; if (o.hstatus !== 64'h2_0000_0000) begin bad++; $display("FAIL single_hstatus got=%h exp=200000000", o.hstatus); end
    total++; if (in_ready !== 2'b11) begin bad++; $display("FAIL single_ready_back got=%b exp=11", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    $display("test_single done");
  endtask

  task automatic test_contention();
    hcsr_snapshot_t d0, d1;
    logic [7:0]     exp_id;
    logic [1:0]     exp_rdy;
    do_reset();
    d0 = mk_snap(16'h0100);
    d1 = mk_snap(16'h0201);
    in_data[0 +: W] = d0;
    in_data[W +: W] = d1;
    in_valid = 2'b11;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cont_first_latency got=%b exp=0", out_valid); end
    for (int k = 2; k < 8; k++) begin
      tick();
      exp_id  = (k % 2 == 0) ? 8'd0 : 8'd1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cont_valid edge=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_coreid !== exp_id) begin bad++; $display("FAIL cont_coreid edge=%0d got=%0d exp=%0d", k, out_coreid, exp_id); end
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL cont_in_ready edge=%0d got=%b exp=%b", k, in_ready, exp_rdy); end
      total++; if (out_data !== ((k % 2 == 0) ? d0 : d1)) begin bad++; $display("FAIL cont_data edge=%0d got=%h", k, out_data[63:0]); end
      $display("contention edge=%0d coreid=%0d in_ready=%b", k, out_coreid, in_ready);
    end
    in_valid = 2'b00;
    $display("test_contention done");
  endtask

  task automatic test_backpressure();
    hcsr_snapshot_t d0, d1;
    do_reset();
    d0 = mk_snap(16'h0300);
    d1 = mk_snap(16'h0401);
    in_data[0 +: W] = d0;
    in_data[W +: W] = d1;
    out_ready = 1'b0;
    in_valid  = 2'b10;
    tick();
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    total++; if (out_coreid !== 8'd1) begin bad++; $display("FAIL bp_first_coreid got=%0d exp=1", out_coreid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_coreid !== 8'd1) begin bad++; $display("FAIL bp_hold_coreid cyc=%0d got=%0d exp=1", k, out_coreid); end
      total++; if (out_data !== d1) begin bad++; $display("FAIL bp_hold_data cyc=%0d got=%h", k, out_data[63:0]); end
      total++; if (in_ready !== 2'b10) begin bad++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=10", k, in_ready); end
      $display("backpressure hold cyc=%0d coreid=%0d", k, out_coreid);
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_coreid !== 8'd0) begin bad++; $display("FAIL bp_release_coreid got=%0d exp=0", out_coreid); end
    total++; if (out_data !== d0) begin bad++; $display("FAIL bp_release_data got=%h", out_data[63:0]); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid got=%b exp=1", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    in_data[0 +: W] = mk_snap(16'h0500);
    in_data[W +: W] = mk_snap(16'h0601);
    out_ready = 1'b0;
    in_valid  = 2'b11;
    tick();
    tick();
    tick();
    in_valid = 2'b00;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    total++; if (in_ready !== 2'b00) begin bad++; $display("FAIL mid_pre_ready got=%b exp=00", in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 2'b11) begin bad++; $display("FAIL mid_ready got=%b exp=11", in_ready); end
    total++; if (out_coreid !== 8'd0) begin bad++; $display("FAIL mid_coreid got=%0d exp=0", out_coreid); end
    out_ready = 1'b1;
    in_valid  = 2'b11;
    tick();
    in_valid = 2'b00;
    tick();
    total++; if (out_coreid !== 8'd0) begin bad++; $display("FAIL mid_ptr_restart got=%0d exp=0", out_coreid); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_restart_valid got=%b exp=1", out_valid); end
    $display("test_reset_midflight done");
  endtask

  task automatic offer0(input hcsr_snapshot_t s);
    int waited;
    waited = 0;
    while (!in_ready[0] && waited < 20) begin
      tick_count();
      waited++;
    end
    total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL dedup_offer_wait got=%b exp=1", in_ready[0]); end
    in_data[0 +: W] = s;
    in_valid[0] = 1'b1;
    tick_count();
    in_valid[0] = 1'b0;
    $display("offer core0 vsepc=%h", s.vsepc);
  endtask

  task automatic test_dedup();
    hcsr_snapshot_t a, b;
    int exp_cnt;
    do_reset();
    out_seen = 0;
    a = '0;
    a.vsepc = 64'h8000_1000;
    b = '0;
    b.vsepc = 64'h8000_1004;
    offer0(a);
    offer0(a);
    offer0(b);
    for (int k = 0; k < 6; k++) tick_count();
`ifdef DIFFTEST_HCSR_DEDUP_EN
    exp_cnt = 2;
`else
    exp_cnt = 3;
`endif
    total++; if (out_seen !== exp_cnt) begin bad++; $display("FAIL dedup_count got=%0d exp=%0d", out_seen, exp_cnt); end
    $display("test_dedup outputs=%0d", out_seen);
  endtask

  task automatic test_coreid_base();
    do_reset();
    out_ready3 = 1'b1;
    in_data3[2*W +: W] = mk_snap(16'h0702);
    in_valid3 = 3'b100;
    tick();
    in_valid3 = 3'b000;
    tick();
    total++; if (out_valid3 !== 1'b1) begin bad++; $display("FAIL base_valid got=%b exp=1", out_valid3); end
    total++; if (out_coreid3 !== 8'd6) begin bad++; $display("FAIL base_coreid got=%0d exp=6", out_coreid3); end
    total++; if (out_data3 !== mk_snap(16'h0702)) begin bad++; $display("FAIL base_data got=%h", out_data3[63:0]); end
    $display("test_coreid_base coreid=%0d", out_coreid3);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = '0;
    in_data    = '0;
    out_ready  = 1'b1;
    in_valid3  = '0;
    in_data3   = '0;
    out_ready3 = 1'b1;
    out_seen   = 0;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    test_dedup();
    test_coreid_base();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
